// File: rtl/aer_in_pkg.sv
// Shared constants and types for the AER input receiver.
package pa_SnnAccelerator;

  localparam int unsigned M                 = 8;
  localparam int unsigned AER_IN_FIFO_DEPTH = 8;
  localparam int unsigned EVT_CNT_W         = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACK_HI = 1'b1
  } aer_in_state_t;

endpackage

// File: rtl/aer_in_if.sv
// AER link + event stream bundle. EVT_CNT exists only with AER_IN_EVT_CNT_EN.
interface aer_in_if
  import pa_SnnAccelerator::*;
#(
  parameter int unsigned M          = pa_SnnAccelerator::M,
  parameter int unsigned FIFO_DEPTH = pa_SnnAccelerator::AER_IN_FIFO_DEPTH
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [M-1:0]     AERIN_ADDR;
  logic             AERIN_REQ;
  logic             AERIN_ACK;
  logic [M-1:0]     EVT_ADDR;
  logic             EVT_VALID;
  logic             EVT_READY;
  logic [CNT_W-1:0] FIFO_COUNT;
`ifdef AER_IN_EVT_CNT_EN
  logic [EVT_CNT_W-1:0] EVT_CNT;
`endif

  // Link sender / event consumer side
  modport master (
    output AERIN_ADDR, AERIN_REQ, EVT_READY,
    input  AERIN_ACK, EVT_ADDR, EVT_VALID, FIFO_COUNT
`ifdef AER_IN_EVT_CNT_EN
    , input EVT_CNT
`endif
  );

  // Receiver side
  modport slave (
    input  AERIN_ADDR, AERIN_REQ, EVT_READY,
    output AERIN_ACK, EVT_ADDR, EVT_VALID, FIFO_COUNT
`ifdef AER_IN_EVT_CNT_EN
    , output EVT_CNT
`endif
  );

endinterface

// File: rtl/aer_in_fifo.sv
// Parameterized first-word-fall-through FIFO; push when full and pop when empty are ignored.
module aer_in_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally at the power-of-two depth
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/aer_in.sv
// AER 4-phase link receiver: REQ synchronizer, handshake FSM and event FIFO.
// Optional accepted-event counter enabled by AER_IN_EVT_CNT_EN.
module aer_in
  import pa_SnnAccelerator::*;
#(
  parameter int unsigned M          = pa_SnnAccelerator::M,
  parameter int unsigned FIFO_DEPTH = pa_SnnAccelerator::AER_IN_FIFO_DEPTH
) (
  input  logic     CLK,
  input  logic     RST,
  aer_in_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic          req_meta_q, req_sync_q;
  aer_in_state_t state_q, state_d;
  logic          ack_q, ack_d;
  logic          push_c;
  logic          fifo_full, fifo_empty;
  logic [M-1:0]     fifo_dout;
  logic [CNT_W-1:0] fifo_count;

  // Two-flop barrier on the asynchronous request
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_meta_q <= 1'b0;
      req_sync_q <= 1'b0;
    end else begin
      req_meta_q <= bus.AERIN_REQ;
      req_sync_q <= req_meta_q;
    end
  end

  // Exactly one push per handshake; a full FIFO withholds ACK
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_sync_q && !fifo_full) begin
          push_c  = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req_sync_q) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  aer_in_fifo #(
    .W     (M),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push_c),
    .pop   (bus.EVT_READY),
    .din   (bus.AERIN_ADDR),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.AERIN_ACK  = ack_q;
  assign bus.EVT_ADDR   = fifo_dout;
  assign bus.EVT_VALID  = ~fifo_empty;
  assign bus.FIFO_COUNT = fifo_count;

`ifdef AER_IN_EVT_CNT_EN
  logic [EVT_CNT_W-1:0] evt_cnt_q, evt_cnt_d;

  always_comb begin
    evt_cnt_d = evt_cnt_q + EVT_CNT_W'(push_c);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) evt_cnt_q <= '0;
    else     evt_cnt_q <= evt_cnt_d;
  end

  assign bus.EVT_CNT = evt_cnt_q;
`endif

endmodule

// File: doc/aer_in.md
Name: aer_in

Overview:
- AER link receiver: the responder end of the 4-phase REQ/ACK address-event link that drives the accelerator's AER input.
- Synchronizes the incoming request and captures the M-bit event address.
- Buffers each event in a small first-word-fall-through (FWFT) FIFO and completes the handshake.
- Presents events to the SNN core over a valid/ready interface; stalls the link by withholding ACK when the buffer is full.

Parameters:
- M, pa_SnnAccelerator::M (8), event address width.
- FIFO_DEPTH, 8, event buffer entries; power of two, >= 2.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- AERIN_ADDR  in  M  event address from link; stable while AERIN_REQ high
- AERIN_REQ  in  1  link request, asynchronous to CLK
- AERIN_ACK  out  1  link acknowledge, registered
- EVT_ADDR  out  M  head-of-FIFO address (FWFT)
- EVT_VALID  out  1  FIFO not empty
- EVT_READY  in  1  consumer pops head when EVT_VALID & EVT_READY
- FIFO_COUNT  out  $clog2(FIFO_DEPTH+1)  current occupancy
- EVT_CNT  out  16  accepted-event counter; present only with AER_IN_EVT_CNT_EN

Behaviour:
- Reset:
  - RST is asynchronous, active-high; clock is CLK.
  - On reset: AERIN_ACK=0, EVT_VALID=0, EVT_ADDR=0, FIFO_COUNT=0, EVT_CNT=0.
  - Pointers and sync flops cleared; FSM returns to IDLE.
- REQ synchronizer: 2-flop barrier gives req_sync. No synchronizer on AERIN_ADDR; it is sampled only when req_sync=1, so it has been stable for >=2 cycles.
- FSM states: IDLE, ACK_HI.
  - IDLE:
    - If req_sync=1 and FIFO not full: push AERIN_ADDR, set AERIN_ACK<=1, go to ACK_HI.
    - If req_sync=1 and FIFO full: stay in IDLE, ACK held 0, nothing captured (backpressure).
  - ACK_HI:
    - Hold ACK=1, no further push.
    - When req_sync=0: AERIN_ACK<=0, go to IDLE.
- Exactly one push per handshake, regardless of how long REQ stays high.
- Latency:
  - REQ rise to ACK rise is 3 CLK edges (2 sync + 1 register).
  - Push is visible on EVT_VALID in the same cycle ACK rises.
  - REQ fall to ACK fall is 3 edges.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)-bit pointers that wrap naturally; count tracks occupancy.
  - Full when count==FIFO_DEPTH; empty when count==0.
  - EVT_ADDR = mem[rd_ptr]; EVT_VALID = (count!=0).
  - Pop when EVT_VALID & EVT_READY; EVT_READY while empty is ignored.
- Simultaneous push and pop (count not full): both happen, count unchanged, pointers both advance.
- Full with pop in the same cycle as req_sync rises: the push is not taken that cycle (full is evaluated on the registered count). It is taken the next cycle.
- Reset mid-handshake: ACK drops immediately, FIFO contents are discarded, FSM goes to IDLE. If REQ is still high after reset release, the event is captured again (duplicate accepted by design).

Optional Feature:
- Macro: AER_IN_EVT_CNT_EN.
- Defined:
  - EVT_CNT port exists.
  - 16-bit counter increments on every push; wraps 0xFFFF to 0x0000.
  - Cleared by RST.
- Undefined: port and counter are removed; all other behaviour is identical.

Decomposition:
- Package pa_SnnAccelerator:
  - M.
  - AER_IN_FIFO_DEPTH default.
  - typedef enum logic {IDLE, ACK_HI} aer_in_state_t.
  - EVT_CNT_W=16.
- Sub-module aer_in_fifo: parameterized FWFT FIFO (push, pop, din, dout, count, full, empty), reusable elsewhere.
- aer_in keeps the synchronizer, FSM and counter.

Test Plan:
- Single event: ADDR=0x5A, REQ rises -> ACK rises after 3 edges; EVT_VALID=1, EVT_ADDR=0x5A. REQ falls -> ACK falls 3 edges later; FIFO_COUNT=1.
- Burst of 8 events, EVT_READY=0: addresses 0x00..0x07 -> FIFO_COUNT=8. 9th REQ (0x08) gets no ACK for 20 cycles. Pulse EVT_READY one cycle -> 0x00 popped, 9th event ACKed, FIFO order 0x01..0x08.
- Long REQ: hold REQ high for 50 cycles with ADDR=0x33 -> exactly one push, FIFO_COUNT=1.
- Concurrent push/pop: FIFO holds 3 entries, EVT_READY=1 continuously while a new event arrives -> count goes 3->2->...; no loss or duplication. Output order matches input order across pointer wrap (push 20 events total).
- Reset mid-handshake: assert RST while ACK=1 -> ACK=0 and EVT_VALID=0 immediately. REQ still high after release -> event re-captured, count=1.
- AER_IN_EVT_CNT_EN: 65537 handshakes -> EVT_CNT=1. With the macro undefined, the build has no EVT_CNT port.
